// File: rtl/preg_reclaim_queue.sv
// Reclaim queue: buffers retired old physical tags (two lanes/cycle) and drains one per cycle to the free list.
// Optional double-free detection is compiled in when RECLAIM_DUP_CHECK_EN is defined.
module preg_reclaim_queue #(
    parameter int unsigned NUM_PHYSICAL_REGS = 64,
    parameter int unsigned TAG_WIDTH         = 6,
    parameter int unsigned QUEUE_DEPTH       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           retire0_valid,
    input  logic                           retire1_valid,
    input  logic                           retire0_has_dest,
    input  logic                           retire1_has_dest,
    input  logic [TAG_WIDTH-1:0]           retire0_old_tag,
    input  logic [TAG_WIDTH-1:0]           retire1_old_tag,
    output logic                           retire_ready,
    input  logic                           fl_full,
    output logic [TAG_WIDTH-1:0]           return_tag,
    output logic                           return_valid,
    output logic [$clog2(QUEUE_DEPTH):0]   pending_count,
    output logic                           queue_empty,
    output logic                           dup_error
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Elaboration-time parameter sanity
    if (QUEUE_DEPTH < 4 || (1 << PW) != QUEUE_DEPTH || NUM_PHYSICAL_REGS > (1 << TAG_WIDTH)) begin : g_param_chk
        $error("preg_reclaim_queue: illegal parameterisation");
    end

    logic [TAG_WIDTH-1:0] mem_q [QUEUE_DEPTH];
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        wr1_idx;
    logic                 qual0, qual1;
    logic                 drop0, drop1;
    logic                 enq0, enq1;

    // Status and drain outputs, all derived from registered state (plus fl_full for the drain)
    always_comb begin
        retire_ready  = (CW'(QUEUE_DEPTH) - count_q) >= CW'(2);
        queue_empty   = (count_q == '0);
        pending_count = count_q;
        return_valid  = !queue_empty && !fl_full;
        return_tag    = queue_empty ? '0 : mem_q[head_q];
    end

    // Tag 0 is the x0 mapping and is never returned to the free list
    always_comb begin
        qual0 = retire0_valid && retire0_has_dest && (retire0_old_tag != '0);
        qual1 = retire1_valid && retire1_has_dest && (retire1_old_tag != '0);
    end

`ifdef RECLAIM_DUP_CHECK_EN
    logic [NUM_PHYSICAL_REGS-1:0] pend_q, pend_d;
    logic                         dup_q, dup_d;

    // A tag already buffered, or repeated across lanes, is a double free: drop it and flag
    always_comb begin
        drop0 = qual0 && pend_q[retire0_old_tag];
        drop1 = qual1 && (pend_q[retire1_old_tag] || (qual0 && (retire1_old_tag == retire0_old_tag)));
    end

    always_comb begin
        pend_d = pend_q;
        if (return_valid) pend_d[return_tag] = 1'b0;
        if (enq0)         pend_d[retire0_old_tag] = 1'b1;
        if (enq1)         pend_d[retire1_old_tag] = 1'b1;
        dup_d = dup_q || (retire_ready && (drop0 || drop1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            dup_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            dup_q  <= dup_d;
        end
    end

    assign dup_error = dup_q;
`else
    always_comb begin
        drop0 = 1'b0;
        drop1 = 1'b0;
    end

    assign dup_error = 1'b0;
`endif

    // Lane 0 occupies the tail slot first; lane 1 follows it
    always_comb begin
        enq0    = retire_ready && qual0 && !drop0;
        enq1    = retire_ready && qual1 && !drop1;
        wr1_idx = tail_q + PW'(enq0);
        head_d  = head_q + PW'(return_valid);
        tail_d  = tail_q + PW'(enq0) + PW'(enq1);
        count_d = count_q + CW'(enq0) + CW'(enq1) - CW'(return_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (enq0) mem_q[tail_q]  <= retire0_old_tag;
            if (enq1) mem_q[wr1_idx] <= retire1_old_tag;
        end
    end

endmodule

// File: doc/preg_reclaim_queue.md
PREG_RECLAIM_QUEUE -- requirements
Module: preg_reclaim_queue

Interface
REQ-001 SHALL have parameter NUM_PHYSICAL_REGS, default 64: number of physical registers.
REQ-002 SHALL have parameter TAG_WIDTH, default 6: physical tag width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 8: reclaim buffer entries; power of 2, minimum 4.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports retire0_valid / retire1_valid, input, 1 each: retirement on lane 0 (older) / lane 1 (younger).
REQ-007 SHALL have ports retire0_has_dest / retire1_has_dest, input, 1 each: the retiring instruction wrote a destination.
REQ-008 SHALL have ports retire0_old_tag / retire1_old_tag, input, TAG_WIDTH each: previous physical mapping to reclaim.
REQ-009 SHALL have port retire_ready, output, 1: queue can accept two entries this cycle.
REQ-010 SHALL have port fl_full, input, 1: downstream free list full; drain stalls.
REQ-011 SHALL have port return_tag, output, TAG_WIDTH: tag returned to the free list.
REQ-012 SHALL have port return_valid, output, 1: return_tag valid this cycle; free list consumes it unconditionally.
REQ-013 SHALL have port pending_count, output, $clog2(QUEUE_DEPTH)+1: entries held.
REQ-014 SHALL have port queue_empty, output, 1: pending_count == 0.
REQ-015 SHALL have port dup_error, output, 1: sticky double-free flag.

Function
REQ-016 SHALL qualify each lane as: valid && has_dest && old_tag != 0; tag 0 (x0 mapping) is never reclaimed.
REQ-017 SHALL enqueue qualified lanes only when retire_ready is 1; lane 0 written before lane 1 when both qualify.
REQ-018 SHALL drive retire_ready = (QUEUE_DEPTH - pending_count) >= 2, from registered state only.
REQ-019 SHALL ignore retire inputs when retire_ready is 0 (protocol violation; no state change).
REQ-020 SHALL drive return_valid = !queue_empty && !fl_full, with return_tag = entry at head pointer, combinationally.
REQ-021 SHALL advance head pointer and remove one entry on every cycle return_valid is 1.
REQ-022 SHALL give one-cycle latency: tag enqueued at edge N is returnable in cycle N+1 at earliest; never same-cycle bypass.
REQ-023 SHALL update pending_count = count + enq(0..2) - deq(0..1) in one cycle for simultaneous enqueue and drain.
REQ-024 SHALL wrap head/tail pointers modulo QUEUE_DEPTH; entries returned in strict FIFO order.
REQ-025 SHALL hold return_tag stable and retain the entry while fl_full is 1.
REQ-026 SHALL drive return_tag to 0 when queue_empty is 1.

Reset
REQ-027 SHALL, on rst high at a clock edge: pointers 0, pending_count 0, queue_empty 1, retire_ready 1, return_valid 0, return_tag 0, dup_error 0.
REQ-028 SHALL discard all buffered entries on reset mid-operation; retire inputs in the reset cycle are ignored.

Configuration
REQ-029 SHALL compile double-free checking only when macro RECLAIM_DUP_CHECK_EN is defined.
REQ-030 SHALL, with RECLAIM_DUP_CHECK_EN: keep NUM_PHYSICAL_REGS-bit pending vector; set bit on enqueue, clear on drain; qualified lane whose tag bit is set, or lane 1 tag equal to qualified lane 0 tag, is dropped and sets dup_error until reset.
REQ-031 SHALL, without RECLAIM_DUP_CHECK_EN: no pending vector, dup_error tied 0, every qualified lane enqueued.

Verification
REQ-032 SHALL cover: reset, lane0 tag 40 qualified, fl_full 0 -> next cycle return_valid 1, return_tag 40, then queue_empty 1.
REQ-033 SHALL cover: both lanes, tags 33 and 34, same cycle -> returned 33 then 34 in consecutive cycles.
REQ-034 SHALL cover: lane0 has_dest 0 tag 35, lane1 tag 0 -> nothing enqueued, pending_count stays 0.
REQ-035 SHALL cover: fill to 7 entries -> retire_ready 0; fl_full 1 for 3 cycles -> return_tag held, count 7; release -> drains in order with pointer wrap.
REQ-036 SHALL cover (RECLAIM_DUP_CHECK_EN): tag 50 enqueued twice before drain -> second dropped, dup_error 1 until rst; without macro -> both returned, dup_error 0.
